iot_event_arbiter: RTL and testbench
====================================

# iot_event_arbiter

Front-end controller for the active-IoT-device monitor counter. It collects "device on" and "device off" events from N independent requesters and grants one per clock, round-robin. It then drives the monitor's `change`/`on_off` inputs with a single-cycle pulse per accepted event. A shadow count prevents the monitor from wrapping below 0 or above its maximum, and events that would cause a wrap are refused with a nack.

## Interface
Parameters:
- `N`, 4 — number of requesters, legal range 2..8.
- `WIDTH`, 8 — count width; must match the monitor's `counter_out` width.

Ports:
- `clk` — input, 1 — single clock; all logic is rising-edge.
- `rst` — input, 1 — reset, asynchronous and active-high.
- `req` — input, N — `req[i]`=1: requester i has an event pending.
- `dir` — input, N — `dir[i]`=1: device on; `dir[i]`=0: device off. Valid while `req[i]`=1.
- `freeze` — input, 1 — while 1, no new grants are issued.
- `ack` — output, N — one-hot, 1-cycle pulse: event accepted.
- `nack` — output, N — one-hot, 1-cycle pulse: event refused (would wrap).
- `change` — output, 1 — to monitor `change`; 1-cycle pulse per accepted event.
- `on_off` — output, 1 — to monitor `on_off`; valid when `change`=1.
- `count` — output, WIDTH — shadow active-device count.
- `nack_count` — output, 8 — number of refused events; saturates at 255.

## Operation
- **Registers:**
  - round-robin pointer `ptr` (0..N-1);
  - `count`;
  - `nack_count`;
  - registered outputs `ack`, `nack`, `change`, `on_off`.
- **Eligibility:** requester i is eligible when `req[i]`=1 and `ack[i]`=0 and `nack[i]`=0. Masking on the current ack/nack gives the requester one cycle to drop or update `req`/`dir`, so no event is processed twice.
- **Winner selection:** the first eligible index searching `ptr`, `ptr`+1, … modulo N. Combinational, from the current inputs and registers.
- **Two control states:**
  - RUN (`freeze`=0): a winner i is processed at each edge.
  - FROZEN (`freeze`=1): no winner. `ack`/`nack`/`change` are 0 the next cycle; `ptr`, `count` and `nack_count` hold.
- **Processing winner i at an edge:**
  - **Reject:** if `dir[i]`=1 and `count`=2^WIDTH-1, or `dir[i]`=0 and `count`=0:
    - `nack[i]`<=1, `change`<=0;
    - `count` unchanged;
    - `nack_count`<=`nack_count`+1, saturating.
  - **Accept:** otherwise:
    - `ack[i]`<=1, `change`<=1, `on_off`<=`dir[i]`;
    - `count`<=`count`+1 if `dir[i]`=1, else `count`-1.
  - **Pointer:** in both cases `ptr`<=(i+1) mod N.
- **No winner:** `ack`, `nack` and `change` go to 0; `on_off` holds its last value; `ptr` holds.
- **Requester protocol:** hold `req`/`dir` stable until `ack` or `nack` is seen. `req` may remain high to present a new event, which is eligible one cycle after the pulse.
- **Reset values:** `ack`=0, `nack`=0, `change`=0, `on_off`=0, `count`=0, `nack_count`=0, `ptr`=0.
- **Reset mid-operation:** all registers clear immediately. In-flight pulses are lost; the monitor is reset by the same `rst`, so the counts stay consistent. Pending requests are re-arbitrated from `ptr`=0 after release.

## Timing
- **Grant latency:** a request sampled at edge k produces `ack`/`nack` high from edge k to edge k+1. Minimum 1 cycle.
- **Monitor update:** `change`/`on_off` are registered at edge k and consumed by the monitor at edge k+1. Monitor `counter_out` equals `count` one cycle after `count` updates.
- **Throughput:**
  - 1 event per cycle overall;
  - a single requester gets at most 1 event per 2 cycles, because of the mask.
- **Fairness:** with all N requesting continuously, each requester is served at least once every N cycles.
- **Freeze:** `freeze` sampled high at edge k means no grant at edge k. Release at edge k allows a grant at that edge.
- **Reset release:** the first grant is possible at the first edge after `rst` falls.

## Test plan
- **Reset:** `rst`=1 for 3 cycles with `req`=1111, `dir`=1111.
  - All outputs 0 throughout.
  - After release: `ack[0]` at the first edge, then `ack[1]`, `ack[2]`, `ack[3]` on successive cycles; `count` steps 1, 2, 3, 4.
- **Single requester:** `req[2]`=1, `dir[2]`=1 held for 10 cycles.
  - `ack[2]` and `change` pulse on alternate cycles; `on_off`=1.
  - `count` reaches 5; monitor `counter_out`=5 one cycle later.
- **Underflow:** `count`=0, single cycle of `req[1]`=1 with `dir[1]`=0.
  - `nack[1]` pulses one cycle; `change` stays 0; `count`=0; `nack_count`=1.
- **Overflow (WIDTH=8):** apply 255 accepted on-events, then one more.
  - Final event gets `nack`; `count`=255; `change` stays 0 for it.
- **Mixed round-robin:** `req`=1111, `dir`=1010, `count` preset to 10 via prior events.
  - Grant order 0, 1, 2, 3 from `ptr`=0.
  - `on_off` sequence 0, 1, 0, 1; `count` returns to 10 after 4 grants.
- **Freeze and mid-operation reset:**
  - `freeze`=1 for 3 cycles with `req[3]`=1 → no `ack`, `change`=0. Drop `freeze` → `ack[3]` at the next edge.
  - Assert `rst` while `change`=1 → `change`, `ack`, `count` read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter for device on/off events feeding the active-device monitor; registered outputs, 1-cycle grant latency.
// Events that would wrap the shadow count are refused with nack; freeze stalls new grants.
module iot_event_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     dir,
    input  logic             freeze,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     nack,
    output logic             change,
    output logic             on_off,
    output logic [WIDTH-1:0] count,
    output logic [7:0]       nack_count
);
    localparam int PW = $clog2(N);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     nack_q, nack_d;
    logic             change_q, change_d;
    logic             on_off_q, on_off_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [7:0]       nack_cnt_q, nack_cnt_d;

    logic [N-1:0]     elig;
    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [PW:0]      sum;
    logic             win_dir;
    logic             reject;

    // A requester just answered is masked for one cycle so it can retire its event.
    assign elig = req & ~ack_q & ~nack_q;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        if (!freeze) begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr_q} + (PW+1)'(k);
                if (sum >= (PW+1)'(N)) begin
                    sum = sum - (PW+1)'(N);
                end
                if (!win_vld && elig[sum[PW-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = sum[PW-1:0];
                end
            end
        end
    end

    assign win_dir = dir[win_idx];
    assign reject  = win_dir ? (count_q == '1) : (count_q == '0);

    always_comb begin
        ack_d      = '0;
        nack_d     = '0;
        change_d   = 1'b0;
        on_off_d   = on_off_q;
        count_d    = count_q;
        nack_cnt_d = nack_cnt_q;
        ptr_d      = ptr_q;
        if (win_vld) begin
            ptr_d = (win_idx == PW'(N-1)) ? '0 : win_idx + 1'b1;
            if (reject) begin
                nack_d[win_idx] = 1'b1;
                if (nack_cnt_q != 8'hFF) begin
                    nack_cnt_d = nack_cnt_q + 8'd1;
                end
            end else begin
                ack_d[win_idx] = 1'b1;
                change_d       = 1'b1;
                on_off_d       = win_dir;
                count_d        = win_dir ? count_q + 1'b1 : count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            ack_q      <= '0;
            nack_q     <= '0;
            change_q   <= 1'b0;
            on_off_q   <= 1'b0;
            count_q    <= '0;
            nack_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            change_q   <= change_d;
            on_off_q   <= on_off_d;
            count_q    <= count_d;
            nack_cnt_q <= nack_cnt_d;
        end
    end

    assign ack        = ack_q;
    assign nack       = nack_q;
    assign change     = change_q;
    assign on_off     = on_off_q;
    assign count      = count_q;
    assign nack_count = nack_cnt_q;
endmodule

// File: tb/tb_iot_event_arbiter.sv
// Bench for iot_event_arbiter: directed scenarios plus random traffic against a behavioural model
// and a simple model of the downstream monitor counter.
module tb_iot_event_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int MAXC  = 2**WIDTH - 1;
    localparam int VW    = 2*N + WIDTH + 10;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             freeze = 1'b0;
    logic [N-1:0]     req    = '0;
    logic [N-1:0]     dir    = '0;
    logic [N-1:0]     ack, nack;
    logic             change, on_off;
    logic [WIDTH-1:0] count;
    logic [7:0]       nack_count;
    logic [WIDTH-1:0] mon;
    logic [VW-1:0]    dut_vec;

    int vectors     = 0;
    int miscompares = 0;

    int           m_ptr, m_count, m_nack_cnt;
    logic [N-1:0] m_ack, m_nack;
    logic         m_change, m_onoff;

    iot_event_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir), .freeze(freeze),
        .ack(ack), .nack(nack), .change(change), .on_off(on_off),
        .count(count), .nack_count(nack_count)
    );

    always #5 clk = ~clk;

    // Downstream monitor: consumes change/on_off one edge after they are registered.
    always @(posedge clk or posedge rst) begin
        if (rst) mon <= '0;
        else if (change) mon <= on_off ? mon + 1'b1 : mon - 1'b1;
    end

    assign dut_vec = {ack, nack, change, on_off, count, nack_count};

    function automatic logic [VW-1:0] model_vec();
        return {m_ack, m_nack, m_change, m_onoff, WIDTH'(m_count), 8'(m_nack_cnt)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_nack_cnt = 0;
        m_ack = '0; m_nack = '0; m_change = 1'b0; m_onoff = 1'b0;
    endtask

    task automatic model_edge();
        logic [N-1:0] elig;
        int w, idx;
        logic d;
        elig = req & ~m_ack & ~m_nack;
        w = -1;
        if (!freeze) begin
            for (int j = 0; j < N; j++) begin
                idx = (m_ptr + j) % N;
                if (w < 0 && ((elig >> idx) & 1) != 0) w = idx;
            end
        end
        m_ack = '0; m_nack = '0; m_change = 1'b0;
        if (w >= 0) begin
            d = ((dir >> w) & 1) != 0;
            if ((d && m_count == MAXC) || (!d && m_count == 0)) begin
                m_nack = N'(1) << w;
                if (m_nack_cnt < 255) m_nack_cnt++;
            end else begin
                m_ack    = N'(1) << w;
                m_change = 1'b1;
                m_onoff  = d;
                m_count += d ? 1 : -1;
            end
            m_ptr = (w + 1) % N;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        req = '0; dir = '0; freeze = 1'b0; rst = 1'b1;
        model_reset();
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '1; dir = '1; freeze = 1'b0; rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (dut_vec !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, dut_vec);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (ack !== N'(1 << c) || count !== WIDTH'(c + 1)) begin
                miscompares++;
                $display("FAIL reset_release_rr grant %0d: ack=%b count=%0d expected ack=%b count=%0d",
                         c, ack, count, N'(1 << c), c + 1);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; dir = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            step();
            vectors++;
            if (ack !== ((c % 2 == 1) ? 4'b0100 : 4'b0000) || change !== (c % 2 == 1) || on_off !== 1'b1) begin
                miscompares++;
                $display("FAIL single_alternate cycle %0d: ack=%b change=%b on_off=%b expected odd-cycle pulses",
                         c, ack, change, on_off);
            end
        end
        vectors++;
        if (count !== 8'd5 || mon !== 8'd5) begin
            miscompares++;
            $display("FAIL single_count: count=%0d monitor=%0d expected 5 and 5", count, mon);
        end
        req = '0;
        step();
    endtask

    task automatic test_underflow();
        do_reset();
        req = 4'b0010; dir = 4'b0000;
        step();
        req = '0;
        vectors++;
        if (nack !== 4'b0010 || ack !== 4'b0000 || change !== 1'b0 || count !== 8'd0 || nack_count !== 8'd1) begin
            miscompares++;
            $display("FAIL underflow_nack: nack=%b ack=%b change=%b count=%0d nack_count=%0d expected 0010 0000 0 0 1",
                     nack, ack, change, count, nack_count);
        end
        step();
        vectors++;
        if (nack !== 4'b0000) begin
            miscompares++;
            $display("FAIL underflow_pulse_width: nack=%b expected 0000", nack);
        end
    endtask

    task automatic test_nack_saturate();
        do_reset();
        req = 4'b0001; dir = 4'b0000;
        for (int c = 0; c < 600; c++) step();
        vectors++;
        if (nack_count !== 8'd255 || count !== 8'd0) begin
            miscompares++;
            $display("FAIL nack_saturate: nack_count=%0d count=%0d expected 255 0", nack_count, count);
        end
        req = '0;
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        req = 4'b0001; dir = 4'b0001;
        for (int c = 0; c < 600 && m_count < MAXC; c++) begin
            step();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL overflow_fill cycle %0d: got %h expected %h", c, dut_vec, model_vec());
            end
        end
        step();
        step();
        vectors++;
        if (nack !== 4'b0001 || ack !== 4'b0000 || change !== 1'b0 || count !== 8'd255 || nack_count !== 8'd1) begin
            miscompares++;
            $display("FAIL overflow_nack: nack=%b ack=%b change=%b count=%0d nack_count=%0d expected 0001 0000 0 255 1",
                     nack, ack, change, count, nack_count);
        end
        req = '0;
        step();
    endtask

    task automatic test_mixed_rr();
        do_reset();
        req = 4'b1000; dir = 4'b1000;
        for (int c = 0; c < 20; c++) step();
        vectors++;
        if (count !== 8'd10) begin
            miscompares++;
            $display("FAIL mixed_preset: count=%0d expected 10", count);
        end
        req = 4'b1111; dir = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (ack !== (N'(1) << c) || on_off !== (c % 2 == 1) || change !== 1'b1 ||
                count !== ((c % 2 == 1) ? 8'd10 : 8'd9)) begin
                miscompares++;
                $display("FAIL mixed_rr grant %0d: ack=%b on_off=%b change=%b count=%0d expected ack=%b on_off=%0d",
                         c, ack, on_off, change, count, N'(1) << c, c % 2);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_freeze_reset();
        do_reset();
        freeze = 1'b1; req = 4'b1000; dir = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if (ack !== 4'b0000 || change !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_hold cycle %0d: ack=%b change=%b expected 0000 0", c, ack, change);
            end
        end
        freeze = 1'b0;
        step();
        vectors++;
        if (ack !== 4'b1000 || change !== 1'b1) begin
            miscompares++;
            $display("FAIL freeze_release: ack=%b change=%b expected 1000 1", ack, change);
        end
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (change !== 1'b0 || ack !== 4'b0000 || count !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: change=%b ack=%b count=%0d expected 0 0000 0", change, ack, count);
        end
        req = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [N-1:0] bit_i;
        int prev_count;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            freeze = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                bit_i = N'(1) << i;
                if ((req & bit_i) == 0 || ((m_ack | m_nack) & bit_i) != 0) begin
                    if ($urandom_range(0, 2) != 0) req |= bit_i; else req &= ~bit_i;
                    if ($urandom_range(0, 1) != 0) dir |= bit_i; else dir &= ~bit_i;
                end
            end
            prev_count = m_count;
            step();
            vectors++;
            if (dut_vec !== model_vec()) begin
                miscompares++;
                $display("FAIL random_model cycle %0d: got %h expected %h", c, dut_vec, model_vec());
            end
            vectors++;
            if (mon !== WIDTH'(prev_count)) begin
                miscompares++;
                $display("FAIL random_monitor cycle %0d: monitor=%0d expected %0d", c, mon, prev_count);
            end
        end
        req = '0; freeze = 1'b0;
        step();
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_single();
        test_underflow();
        test_nack_saturate();
        test_overflow();
        test_mixed_rr();
        test_freeze_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
